bcd_time_counter: RTL and testbench

- Time-of-day counter that produces the BCD hours/minutes/seconds bus consumed by the hourly chime stage.
- Counts 00:00:00 to 23:59:59 on a 1 Hz enable and supports full-time load and per-field adjust.
- Flags rollovers for downstream logic.
- Sits directly upstream of the chime/ring logic and the display mux.

---
 rtl/bcd_time_counter_if.sv | 41 ++++
 rtl/bcd_time_counter.sv | 156 +++++++++++++++
 tb/tb_bcd_time_counter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - control/time bus between the time counter and its neighbours
//
// Groups the load/adjust/tick controls and the BCD time and pulse outputs.
//   master : drives tick_en, hold, load, ld_*, adj_*; observes time and pulses
//   slave  : the counter itself
//
// Signals:
//   tick_en                  1 Hz count enable, one cycle wide
//   hold                     freeze counting (load/adjust still honoured)
//   load, ld_hours/minte/secd  full-time load strobe and BCD values
//   adj_sel, adj_inc         per-field adjust select and strobe
//   hours, minte, secd       BCD time of day
//   sec_pulse, hour_pulse    one-cycle event flags
//   load_err                 one-cycle flag for a rejected load

interface bcd_time_counter_if;
    logic       tick_en;
    logic       hold;
    logic       load;
    logic [7:0] ld_hours;
    logic [7:0] ld_minte;
    logic [7:0] ld_secd;
    logic [1:0] adj_sel;
    logic       adj_inc;
    logic [7:0] hours;
    logic [7:0] minte;
    logic [7:0] secd;
    logic       sec_pulse;
    logic       hour_pulse;
    logic       load_err;

    modport master (
        output tick_en, hold, load, ld_hours, ld_minte, ld_secd, adj_sel, adj_inc,
        input  hours, minte, secd, sec_pulse, hour_pulse, load_err
    );

    modport slave (
        input  tick_en, hold, load, ld_hours, ld_minte, ld_secd, adj_sel, adj_inc,
        output hours, minte, secd, sec_pulse, hour_pulse, load_err
    );
endinterface

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD hh:mm:ss time-of-day counter with load, adjust and rollover flags
//
// Counts 00:00:00 .. HOUR_MAX:59:59 on an accepted seconds tick. Per-cycle
// priority is load > adjust > tick; a lower-priority event in the same cycle
// is dropped. All outputs are registered.
//
// Ports:
//   cp   in   system clock, posedge
//   rst  in   asynchronous active-low reset
//   bus  slave modport of bcd_time_counter_if (controls in, time/pulses out)
//
// Parameters:
//   DIV       cp cycles per seconds tick when the internal prescaler is built (>= 2)
//   HOUR_MAX  highest BCD hour; the next hour increment wraps to 8'h00
//
// Build option:
//   CLK_PRESCALE_EN  when defined, an internal 0..DIV-1 prescaler replaces
//                    bus.tick_en as the tick source. It restarts on reset and
//                    on an accepted load, and keeps running while hold is high.

module bcd_time_counter #(
    parameter int         DIV      = 50000000,
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic              cp,
    input  logic              rst,
    bcd_time_counter_if.slave bus
);

    logic [7:0] hours_q;
    logic [7:0] minte_q;
    logic [7:0] secd_q;
    logic       sec_pulse_q;
    logic       hour_pulse_q;
    logic       load_err_q;

    // 00..59 field with both nibbles in range.
    function automatic logic sexa_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // With both nibbles <= 9, BCD ordering equals numeric ordering, so a
    // plain compare against HOUR_MAX is valid.
    function automatic logic hour_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= HOUR_MAX);
    endfunction

    // An out-of-range field (only reachable by forcing) restarts at 00.
    function automatic logic [7:0] sexa_inc(input logic [7:0] v);
        if (!sexa_ok(v) || (v == 8'h59)) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] v);
        if (!hour_ok(v) || (v == HOUR_MAX)) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    logic load_ok;
    logic adj_req;
    logic tick_src;
    logic tick_ok;
    logic min_carry;
    logic hour_carry;

    assign load_ok    = bus.load && sexa_ok(bus.ld_secd) && sexa_ok(bus.ld_minte)
                        && hour_ok(bus.ld_hours);
    assign adj_req    = bus.adj_inc && (bus.adj_sel != 2'b00);
    assign tick_ok    = tick_src && !bus.hold && !bus.load && !adj_req;
    assign min_carry  = (secd_q == 8'h59);
    assign hour_carry = min_carry && (minte_q == 8'h59);

`ifdef CLK_PRESCALE_EN
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;

    assign tick_src = (presc == PW'(DIV - 1));

    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (load_ok || tick_src) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    assign tick_src = bus.tick_en;

    // DIV only sizes the prescaler; nothing to build here.
    if (DIV < 2) begin : g_div_unused
    end
`endif

    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            hours_q      <= 8'h00;
            minte_q      <= 8'h00;
            secd_q       <= 8'h00;
            sec_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            sec_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    hours_q <= bus.ld_hours;
                    minte_q <= bus.ld_minte;
                    secd_q  <= bus.ld_secd;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (adj_req) begin
                case (bus.adj_sel)
                    2'b01:   secd_q  <= 8'h00;
                    2'b10:   minte_q <= sexa_inc(minte_q);
                    2'b11:   hours_q <= hour_inc(hours_q);
                    default: ;
                endcase
            end else if (tick_ok) begin
                sec_pulse_q  <= 1'b1;
                hour_pulse_q <= hour_carry;
                secd_q       <= sexa_inc(secd_q);
                // Fields not carried into are still scrubbed if out of range.
                if (min_carry || !sexa_ok(minte_q)) begin
                    minte_q <= sexa_inc(minte_q);
                end
                if (hour_carry || !hour_ok(hours_q)) begin
                    hours_q <= hour_inc(hours_q);
                end
            end
        end
    end

    assign bus.hours      = hours_q;
    assign bus.minte      = minte_q;
    assign bus.secd       = secd_q;
    assign bus.sec_pulse  = sec_pulse_q;
    assign bus.hour_pulse = hour_pulse_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter

module tb_bcd_time_counter;
    localparam int DIV = 4;

    logic cp  = 1'b0;
    logic rst = 1'b0;

    bcd_time_counter_if bus ();

    bcd_time_counter #(.DIV(DIV), .HOUR_MAX(8'h23)) dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus)
    );

    always #5 cp = ~cp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference time kept as plain integers.
    int   m_h = 0, m_m = 0, m_s = 0, m_pc = 0;
    logic e_sp = 1'b0, e_hp = 1'b0, e_le = 1'b0;
    int   n_sp = 0, n_hp = 0;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit fld_ok(input logic [7:0] v, input int maxv);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec(v) <= maxv);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference, then compare after the edge.
    task automatic step(input logic te, input logic ho, input logic ld,
                        input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                        input logic [1:0] as, input logic ai);
        logic tsrc;
        logic lok;
        int   t;
        bus.tick_en  = te;
        bus.hold     = ho;
        bus.load     = ld;
        bus.ld_hours = lh;
        bus.ld_minte = lm;
        bus.ld_secd  = ls;
        bus.adj_sel  = as;
        bus.adj_inc  = ai;
`ifdef CLK_PRESCALE_EN
        tsrc = (m_pc == DIV - 1);
`else
        tsrc = te;
`endif
        e_sp = 1'b0;
        e_hp = 1'b0;
        e_le = 1'b0;
        lok  = 1'b0;
        if (ld) begin
            if (fld_ok(lh, 23) && fld_ok(lm, 59) && fld_ok(ls, 59)) begin
                lok = 1'b1;
                m_h = dec(lh);
                m_m = dec(lm);
                m_s = dec(ls);
            end else begin
                e_le = 1'b1;
            end
        end else if (ai && as != 2'd0) begin
            case (as)
                2'd1:    m_s = 0;
                2'd2:    m_m = (m_m + 1) % 60;
                default: m_h = (m_h + 1) % 24;
            endcase
        end else if (tsrc && !ho) begin
            t    = m_h * 3600 + m_m * 60 + m_s;
            e_sp = 1'b1;
            e_hp = ((t % 3600) == 3599);
            t    = (t + 1) % 86400;
            m_h  = t / 3600;
            m_m  = (t / 60) % 60;
            m_s  = t % 60;
        end
        m_pc = lok ? 0 : (m_pc + 1) % DIV;
        @(posedge cp);
        #1;
        n_sp += int'(bus.sec_pulse);
        n_hp += int'(bus.hour_pulse);
        check("cycle", {bus.hours, bus.minte, bus.secd, bus.sec_pulse, bus.hour_pulse, bus.load_err},
              {bcd(m_h), bcd(m_m), bcd(m_s), e_sp, e_hp, e_le});
    endtask

    task automatic idle(input logic te);
        step(te, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic do_load(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
        step(1'b0, 1'b0, 1'b1, lh, lm, ls, 2'b00, 1'b0);
    endtask

    task automatic adjust(input logic [1:0] as);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, as, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick_en  = 1'b0;
        bus.hold     = 1'b0;
        bus.load     = 1'b0;
        bus.ld_hours = 8'h00;
        bus.ld_minte = 8'h00;
        bus.ld_secd  = 8'h00;
        bus.adj_sel  = 2'b00;
        bus.adj_inc  = 1'b0;

        repeat (2) @(posedge cp);
        #1;
        check("reset_time", {bus.hours, bus.minte, bus.secd}, 24'h000000);
        check("reset_pulses", {bus.sec_pulse, bus.hour_pulse, bus.load_err}, 3'b000);
        @(negedge cp);
        rst = 1'b1;
        idle(1'b0);

`ifndef CLK_PRESCALE_EN
        n_sp = 0;
        n_hp = 0;
        for (int i = 0; i < 60; i++) begin
            idle(1'b1);
            check("count_secd", bus.secd, bcd((i + 1) % 60));
            idle(1'b0);
        end
        check("count_minte", bus.minte, 8'h01);
        check("count_sec_pulses", n_sp, 60);
        check("count_hour_pulses", n_hp, 0);

        do_load(8'h23, 8'h59, 8'h58);
        check("load_2359", {bus.hours, bus.minte, bus.secd}, 24'h235958);
        idle(1'b1);
        check("tick_235959", {bus.hours, bus.minte, bus.secd, bus.hour_pulse}, {24'h235959, 1'b0});
        idle(1'b1);
        check("wrap_000000", {bus.hours, bus.minte, bus.secd, bus.sec_pulse, bus.hour_pulse},
              {24'h000000, 2'b11});

        do_load(8'h12, 8'h5A, 8'h00);
        check("bad_minte_err", {bus.load_err, bus.hours, bus.minte, bus.secd}, {1'b1, 24'h000000});
        idle(1'b0);
        check("bad_minte_err_clr", bus.load_err, 1'b0);
        do_load(8'h24, 8'h00, 8'h00);
        check("bad_hours_err", {bus.load_err, bus.hours, bus.minte, bus.secd}, {1'b1, 24'h000000});
        idle(1'b0);

        do_load(8'h10, 8'h59, 8'h30);
        n_sp = 0;
        n_hp = 0;
        adjust(2'b10);
        check("adj_min_wrap", {bus.hours, bus.minte, bus.secd}, 24'h100030);
        repeat (14) adjust(2'b11);
        check("adj_hour_wrap", {bus.hours, bus.minte, bus.secd}, 24'h000030);
        adjust(2'b01);
        check("adj_sec_clear", {bus.hours, bus.minte, bus.secd}, 24'h000000);
        check("adj_no_pulses", n_sp + n_hp, 0);

        step(1'b1, 1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 2'b11, 1'b1);
        check("priority_load", {bus.hours, bus.minte, bus.secd, bus.sec_pulse}, {24'h070000, 1'b0});
        n_sp = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
        check("hold_frozen", {bus.hours, bus.minte, bus.secd}, 24'h070000);
        check("hold_no_pulses", n_sp, 0);
        idle(1'b1);
        check("hold_resume", bus.secd, 8'h01);
`else
        begin
            int first;
            int gap;
            first = -1;
            gap   = -1;
            do_load(8'h05, 8'h06, 8'h07);
            for (int i = 1; i <= 10 && first < 0; i++) begin
                idle(1'b0);
                if (bus.sec_pulse) first = i;
            end
            check("presc_first_tick", first, 4);
            for (int i = 1; i <= 10 && gap < 0; i++) begin
                idle(1'b1);
                if (bus.sec_pulse) gap = i;
            end
            check("presc_period", gap, DIV);
        end
`endif

        // Asynchronous reset between edges, with a pulse currently high.
        do_load(8'h01, 8'h02, 8'h03);
        while (!bus.sec_pulse && n_checks < 5000) idle(1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", {bus.hours, bus.minte, bus.secd, bus.sec_pulse, bus.hour_pulse, bus.load_err},
              27'd0);
        m_h  = 0;
        m_m  = 0;
        m_s  = 0;
        m_pc = 0;
        @(negedge cp);
        rst = 1'b1;
        idle(1'b0);

        for (int i = 0; i < 400; i++) begin
            logic       ld;
            logic [7:0] lh, lm, ls;
            ld = ($urandom % 16 == 0);
            if ($urandom % 2 == 0) begin
                lh = bcd(($urandom % 3 == 0) ? 23 : int'($urandom % 24));
                lm = bcd(($urandom % 2 == 0) ? 59 : int'($urandom % 60));
                ls = bcd(55 + int'($urandom % 5));
            end else begin
                lh = 8'($urandom);
                lm = 8'($urandom);
                ls = 8'($urandom);
            end
            step(1'($urandom), ($urandom % 10 == 0), ld, lh, lm, ls,
                 2'($urandom), ($urandom % 8 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
